// File: rtl/regfile_param.sv
// Parametrised register file: two prioritised write ports, NREAD combinational read ports,
// optional write-to-read bypass, optional hard-wired zero register and a per-register busy scoreboard.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    output logic [NREAD-1:0]       ReadBusy,
    input  logic                   RegWrite0,
    input  logic [AW-1:0]          WriteRegister0,
    input  logic [WIDTH-1:0]       WriteData0,
    input  logic                   RegWrite1,
    input  logic [AW-1:0]          WriteRegister1,
    input  logic [WIDTH-1:0]       WriteData1,
    input  logic                   Reserve,
    input  logic [AW-1:0]          ReserveRegister
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wrEn0;
    logic wrEn1;
    logic resEn;

    // Enables are masked by reset so that bypassed data never leaks out while in reset.
    always_comb begin
        wrEn0 = RegWrite0 & Reset_n;
        wrEn1 = RegWrite1 & Reset_n;
        resEn = Reserve   & Reset_n;
        if (ZERO_REG != 0) begin
            if (WriteRegister0 == '0)  wrEn0 = 1'b0;
            if (WriteRegister1 == '0)  wrEn1 = 1'b0;
            if (ReserveRegister == '0) resEn = 1'b0;
        end
    end

    // Port 1 is applied after port 0 so it wins a collision; reserve last so a new producer stays busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wrEn0) begin
            regs_d[WriteRegister0] = WriteData0;
            busy_d[WriteRegister0] = 1'b0;
        end
        if (wrEn1) begin
            regs_d[WriteRegister1] = WriteData1;
            busy_d[WriteRegister1] = 1'b0;
        end
        if (resEn) begin
            busy_d[ReserveRegister] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [WIDTH-1:0] rdData [NREAD];
    logic             rdBusy [NREAD];

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] rdAddr;
        logic          hit0;
        logic          hit1;
        logic          resHit;

        assign rdAddr = ReadRegister[k*AW +: AW];
        assign hit0   = (BYPASS != 0) && wrEn0 && (WriteRegister0 == rdAddr);
        assign hit1   = (BYPASS != 0) && wrEn1 && (WriteRegister1 == rdAddr);
        assign resHit = resEn && (ReserveRegister == rdAddr);

        // A bypassed register is only busy if it is being re-reserved in the same cycle.
        always_comb begin
            rdData[k] = regs_q[rdAddr];
            rdBusy[k] = busy_q[rdAddr];
            if (hit1) begin
                rdData[k] = WriteData1;
                rdBusy[k] = resHit;
            end else if (hit0) begin
                rdData[k] = WriteData0;
                rdBusy[k] = resHit;
            end
            if ((ZERO_REG != 0) && (rdAddr == '0)) begin
                rdData[k] = '0;
                rdBusy[k] = 1'b0;
            end
        end

        assign ReadData[k*WIDTH +: WIDTH] = rdData[k];
        assign ReadBusy[k]                = rdBusy[k];
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed checks on bypass and non-bypass builds, then randomized
// traffic with reset pulses on a 4-port 16x16 build against an array-based reference model.
module tb_regfile_param;

    logic Clk;
    int   total = 0;
    int   bad   = 0;

    // Default build (32x32, two read ports, bypass on)
    logic        aRstN;
    logic [9:0]  aRr;
    logic [63:0] aRd;
    logic [1:0]  aRb;
    logic        aWe0, aWe1, aRes;
    logic [4:0]  aWa0, aWa1, aResReg;
    logic [31:0] aWd0, aWd1;

    // Non-bypass build
    logic        bRstN;
    logic [9:0]  bRr;
    logic [63:0] bRd;
    logic [1:0]  bRb;
    logic        bWe0, bWe1, bRes;
    logic [4:0]  bWa0, bWa1, bResReg;
    logic [31:0] bWd0, bWd1;

    // Randomized build (16x16, four read ports)
    logic        cRstN;
    logic [15:0] cRr;
    logic [63:0] cRd;
    logic [3:0]  cRb;
    logic        cWe0, cWe1, cRes;
    logic [3:0]  cWa0, cWa1, cResReg;
    logic [15:0] cWd0, cWd1;

    logic [15:0] mMem  [16];
    logic        mBusy [16];

    regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dutA (
        .Clk(Clk), .Reset_n(aRstN), .ReadRegister(aRr), .ReadData(aRd), .ReadBusy(aRb),
        .RegWrite0(aWe0), .WriteRegister0(aWa0), .WriteData0(aWd0),
        .RegWrite1(aWe1), .WriteRegister1(aWa1), .WriteData1(aWd1),
        .Reserve(aRes), .ReserveRegister(aResReg)
    );

    regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dutB (
        .Clk(Clk), .Reset_n(bRstN), .ReadRegister(bRr), .ReadData(bRd), .ReadBusy(bRb),
        .RegWrite0(bWe0), .WriteRegister0(bWa0), .WriteData0(bWd0),
        .RegWrite1(bWe1), .WriteRegister1(bWa1), .WriteData1(bWd1),
        .Reserve(bRes), .ReserveRegister(bResReg)
    );

    regfile_param #(.WIDTH(16), .DEPTH(16), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) dutC (
        .Clk(Clk), .Reset_n(cRstN), .ReadRegister(cRr), .ReadData(cRd), .ReadBusy(cRb),
        .RegWrite0(cWe0), .WriteRegister0(cWa0), .WriteData0(cWd0),
        .RegWrite1(cWe1), .WriteRegister1(cWa1), .WriteData1(cWd1),
        .Reserve(cRes), .ReserveRegister(cResReg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic aIdle();
        aWe0 = 1'b0; aWe1 = 1'b0; aRes = 1'b0;
    endtask

    task automatic bIdle();
        bWe0 = 1'b0; bWe1 = 1'b0; bRes = 1'b0;
    endtask

    // Expected read result from the reference model plus this cycle's inputs.
    function automatic void expRead(input logic [3:0] a, output logic [15:0] d, output logic b);
        d = mMem[a];
        b = mBusy[a];
        if (!cRstN || a == 4'd0) begin
            d = '0;
            b = 1'b0;
            return;
        end
        if (cWe1 && cWa1 == a) begin
            d = cWd1;
            b = cRes && (cResReg == a);
        end else if (cWe0 && cWa0 == a) begin
            d = cWd0;
            b = cRes && (cResReg == a);
        end
    endfunction

    task automatic checkAllC(input string tag);
        logic [15:0] d;
        logic        b;
        for (int k = 0; k < 4; k++) begin
            expRead(cRr[k*4 +: 4], d, b);
            checkOutput($sformatf("%s.data%0d", tag, k), 64'(cRd[k*16 +: 16]), 64'(d));
            checkOutput($sformatf("%s.busy%0d", tag, k), 64'(cRb[k]), 64'(b));
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mMem[i]  = '0;
            mBusy[i] = 1'b0;
        end
    endtask

    task automatic modelEdge();
        if (cWe0 && cWa0 != 4'd0) begin
            mMem[cWa0]  = cWd0;
            mBusy[cWa0] = 1'b0;
        end
        if (cWe1 && cWa1 != 4'd0) begin
            mMem[cWa1]  = cWd1;
            mBusy[cWa1] = 1'b0;
        end
        if (cRes && cResReg != 4'd0) mBusy[cResReg] = 1'b1;
    endtask

    task automatic applyStimulus();
        int pick;
        cWe0    = 1'($urandom_range(1, 0));
        cWe1    = 1'($urandom_range(1, 0));
        cRes    = 1'($urandom_range(3, 0) == 0);
        cWa0    = 4'($urandom_range(15, 0));
        cWa1    = ($urandom_range(3, 0) == 0) ? cWa0 : 4'($urandom_range(15, 0));
        cResReg = ($urandom_range(3, 0) == 0) ? cWa1 : 4'($urandom_range(15, 0));
        cWd0    = 16'($urandom);
        cWd1    = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            pick = $urandom_range(2, 0);
            if (pick == 0)      cRr[k*4 +: 4] = cWa0;
            else if (pick == 1) cRr[k*4 +: 4] = cWa1;
            else                cRr[k*4 +: 4] = 4'($urandom_range(15, 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aRstN = 1'b0; bRstN = 1'b0; cRstN = 1'b0;
        aIdle(); bIdle();
        aWa0 = '0; aWa1 = '0; aResReg = '0; aWd0 = '0; aWd1 = '0; aRr = '0;
        bWa0 = '0; bWa1 = '0; bResReg = '0; bWd0 = '0; bWd1 = '0; bRr = '0;
        cWe0 = 1'b0; cWe1 = 1'b0; cRes = 1'b0;
        cWa0 = '0; cWa1 = '0; cResReg = '0; cWd0 = '0; cWd1 = '0; cRr = '0;
        modelReset();
        repeat (2) @(negedge Clk);
        #1 checkOutput("init.data", aRd, 64'd0);
        checkOutput("init.busy", 64'(aRb), 64'd0);
        aRstN = 1'b1; bRstN = 1'b1; cRstN = 1'b1;

        // Preload r5 and reserve r7, then pulse reset mid-cycle
        @(negedge Clk);
        aWe0 = 1'b1; aWa0 = 5'd5; aWd0 = 32'hDEADBEEF;
        aRes = 1'b1; aResReg = 5'd7;
        aRr  = {5'd7, 5'd5};
        #1 checkOutput("pre.byp", 64'(aRd[31:0]), 64'hDEADBEEF);
        checkOutput("pre.rsvnobyp", 64'(aRb[1]), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("pre.r5", 64'(aRd[31:0]), 64'hDEADBEEF);
        checkOutput("pre.r7busy", 64'(aRb[1]), 64'd1);
        aRstN = 1'b0;
        #1 checkOutput("rst.data", aRd, 64'd0);
        checkOutput("rst.busy", 64'(aRb), 64'd0);
        aRstN = 1'b1;
        #1 checkOutput("postrst.data", aRd, 64'd0);
        checkOutput("postrst.busy", 64'(aRb), 64'd0);

        // Basic write/read and zero register
        @(negedge Clk);
        aWe0 = 1'b1; aWa0 = 5'd3; aWd0 = 32'h12345678;
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        aRr = {5'd3, 5'd3};
        #1 checkOutput("r3.port0", 64'(aRd[31:0]), 64'h12345678);
        checkOutput("r3.port1", 64'(aRd[63:32]), 64'h12345678);
        aWe0 = 1'b1; aWa0 = 5'd0; aWd0 = 32'hFFFFFFFF;
        aRr  = {5'd0, 5'd0};
        #1 checkOutput("r0.byp", aRd, 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("r0.read", aRd, 64'd0);

        // Write collision: port 1 wins
        aWe0 = 1'b1; aWa0 = 5'd9; aWd0 = 32'h1;
        aWe1 = 1'b1; aWa1 = 5'd9; aWd1 = 32'h2;
        aRr  = {5'd9, 5'd9};
        #1 checkOutput("coll.byp", 64'(aRd[31:0]), 64'h2);
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("coll.read", 64'(aRd[63:32]), 64'h2);

        // Scoreboard
        aRes = 1'b1; aResReg = 5'd4;
        aRr  = {5'd4, 5'd4};
        #1 checkOutput("rsv.same", 64'(aRb), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("rsv.next", 64'(aRb), 64'b11);
        aWe0 = 1'b1; aWa0 = 5'd4; aWd0 = 32'hA5;
        #1 checkOutput("wr.bypbusy", 64'(aRb), 64'd0);
        checkOutput("wr.bypdata", 64'(aRd[31:0]), 64'hA5);
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("wr.busyclr", 64'(aRb), 64'd0);
        checkOutput("wr.data", 64'(aRd[63:32]), 64'hA5);
        aWe1 = 1'b1; aWa1 = 5'd4; aWd1 = 32'hA5;
        aRes = 1'b1; aResReg = 5'd4;
        #1 checkOutput("rsvwr.bypbusy", 64'(aRb), 64'b11);
        checkOutput("rsvwr.bypdata", 64'(aRd[31:0]), 64'hA5);
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("rsvwr.busy", 64'(aRb), 64'b11);
        checkOutput("rsvwr.data", 64'(aRd[31:0]), 64'hA5);
        aRes = 1'b1; aResReg = 5'd0;
        aRr  = {5'd0, 5'd0};
        @(posedge Clk);
        @(negedge Clk);
        aIdle();
        #1 checkOutput("rsv.r0", 64'(aRb), 64'd0);

        // Non-bypass build
        bWe0 = 1'b1; bWa0 = 5'd2; bWd0 = 32'h55;
        bRr  = {5'd2, 5'd2};
        #1 checkOutput("nobyp.old", 64'(bRd[31:0]), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        bIdle();
        #1 checkOutput("nobyp.new", 64'(bRd[31:0]), 64'h55);
        bWe1 = 1'b1; bWa1 = 5'd6; bWd1 = 32'h77;
        bRes = 1'b1; bResReg = 5'd6;
        bRr  = {5'd6, 5'd6};
        #1 checkOutput("nobyp.rsvold", 64'(bRb), 64'd0);
        checkOutput("nobyp.dataold", 64'(bRd[63:32]), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        bIdle();
        #1 checkOutput("nobyp.rsvnew", 64'(bRb), 64'b11);
        checkOutput("nobyp.datanew", 64'(bRd[63:32]), 64'h77);

        // Randomized traffic with occasional reset pulses
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge Clk);
            applyStimulus();
            if ($urandom_range(99, 0) == 0) begin
                cRstN = 1'b0;
                modelReset();
                #1 checkAllC("rst");
                cRstN = 1'b1;
            end
            #1 checkAllC("rnd");
            @(posedge Clk);
            modelEdge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
